// File: rtl/bscan_arbiter.sv
// Round-robin sharing of one Bscan user-register channel among NCLIENT requesters,
// with tag-steered inbound responses held in per-client 2-entry queues.
module bscan_arbiter #(
  parameter int unsigned NCLIENT = 4,
  parameter int unsigned TAGW    = 2,
  parameter int unsigned width   = 32,
  parameter int unsigned PAYW    = width - 1 - TAGW
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NCLIENT-1:0]      req__ENA,
  input  logic [NCLIENT*PAYW-1:0] req_v,
  output logic [NCLIENT-1:0]      req__RDY,
  output logic                    toBscan_enq__ENA,
  output logic [width-1:0]        toBscan_enq_v,
  input  logic                    toBscan_enq__RDY,
  input  logic                    fromBscan_enq__ENA,
  input  logic [width-1:0]        fromBscan_enq_v,
  output logic                    fromBscan_enq__RDY,
  output logic [NCLIENT-1:0]      rsp__ENA,
  output logic [NCLIENT*PAYW-1:0] rsp_v,
  input  logic [NCLIENT-1:0]      rsp__RDY,
  output logic [7:0]              drop_cnt,
  output logic [15:0]             tx_cnt
);

  localparam int unsigned CNTW  = 2;
  localparam int unsigned DROPW = 8;
  localparam int unsigned TXW   = 16;

  // Outbound (request) queues
  logic [PAYW-1:0]    oq_mem_q [NCLIENT][2];
  logic [CNTW-1:0]    oq_cnt_q [NCLIENT];
  logic [CNTW-1:0]    oq_cnt_d [NCLIENT];
  logic [NCLIENT-1:0] oq_rd_q, oq_rd_d;

  // Inbound (response) queues
  logic [PAYW-1:0]    rq_mem_q [NCLIENT][2];
  logic [CNTW-1:0]    rq_cnt_q [NCLIENT];
  logic [CNTW-1:0]    rq_cnt_d [NCLIENT];
  logic [NCLIENT-1:0] rq_rd_q, rq_rd_d;

  logic [TAGW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;
  logic [TXW-1:0]   tx_cnt_q, tx_cnt_d;

  logic               grant_c, found_c;
  logic [TAGW-1:0]    winner_c, idx_c;
  logic [NCLIENT-1:0] opush_c, opop_c, rpush_c, rpop_c;
  logic               in_valid_c, drop_c;
  logic [TAGW-1:0]    in_tag_c;
  logic [PAYW-1:0]    in_pay_c;

  assign drop_cnt = drop_cnt_q;
  assign tx_cnt   = tx_cnt_q;

  // First non-empty outbound queue searching upward from rr_ptr
  always_comb begin
    found_c  = 1'b0;
    winner_c = rr_ptr_q;
    idx_c    = '0;
    for (int k = 0; k < NCLIENT; k++) begin
      idx_c = rr_ptr_q + TAGW'(k);
      if (!found_c && oq_cnt_q[idx_c] != '0) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
  end

  always_comb begin
    grant_c            = toBscan_enq__RDY && !nRST;
    toBscan_enq__ENA   = grant_c;
    toBscan_enq_v      = '0;
    fromBscan_enq__RDY = !nRST;
    in_valid_c         = fromBscan_enq__ENA && fromBscan_enq_v[width-1] && !nRST;
    in_tag_c           = fromBscan_enq_v[width-2 -: TAGW];
    in_pay_c           = fromBscan_enq_v[PAYW-1:0];
    drop_c             = 1'b0;
    req__RDY           = '0;
    rsp__ENA           = '0;
    rsp_v              = '0;
    opush_c            = '0;
    opop_c             = '0;
    rpush_c            = '0;
    rpop_c             = '0;
    if (grant_c && found_c) begin
      toBscan_enq_v = {1'b1, winner_c, oq_mem_q[winner_c][oq_rd_q[winner_c]]};
    end
    for (int i = 0; i < NCLIENT; i++) begin
      req__RDY[i]            = !nRST && (oq_cnt_q[i] != CNTW'(2));
      opush_c[i]             = req__ENA[i] && req__RDY[i];
      opop_c[i]              = grant_c && found_c && (winner_c == TAGW'(i));
      rsp__ENA[i]            = !nRST && (rq_cnt_q[i] != '0) && rsp__RDY[i];
      rpop_c[i]              = rsp__ENA[i];
      rsp_v[i*PAYW +: PAYW]  = rq_mem_q[i][rq_rd_q[i]];
      // A full queue still accepts when its head leaves in the same cycle
      rpush_c[i] = in_valid_c && (in_tag_c == TAGW'(i)) &&
                   ((rq_cnt_q[i] != CNTW'(2)) || rpop_c[i]);
    end
    drop_c = in_valid_c && (rq_cnt_q[in_tag_c] == CNTW'(2)) && !rpop_c[in_tag_c];
  end

  always_comb begin
    oq_rd_d    = oq_rd_q ^ opop_c;
    rq_rd_d    = rq_rd_q ^ rpop_c;
    rr_ptr_d   = rr_ptr_q;
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NCLIENT; i++) begin
      oq_cnt_d[i] = oq_cnt_q[i] + CNTW'(opush_c[i]) - CNTW'(opop_c[i]);
      rq_cnt_d[i] = rq_cnt_q[i] + CNTW'(rpush_c[i]) - CNTW'(rpop_c[i]);
    end
    if (grant_c && found_c) begin
      rr_ptr_d = winner_c + TAGW'(1);
      tx_cnt_d = tx_cnt_q + TXW'(1);
    end
    if (drop_c && drop_cnt_q != {DROPW{1'b1}}) begin
      drop_cnt_d = drop_cnt_q + DROPW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < NCLIENT; i++) begin
        oq_cnt_q[i] <= '0;
        rq_cnt_q[i] <= '0;
      end
      oq_rd_q    <= '0;
      rq_rd_q    <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NCLIENT; i++) begin
        oq_cnt_q[i] <= oq_cnt_d[i];
        rq_cnt_q[i] <= rq_cnt_d[i];
      end
      oq_rd_q    <= oq_rd_d;
      rq_rd_q    <= rq_rd_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Tail slot is rd+cnt mod 2; with a full queue being popped that is the head slot leaving
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCLIENT; i++) begin
      if (opush_c[i]) begin
        oq_mem_q[i][oq_rd_q[i] ^ oq_cnt_q[i][0]] <= req_v[i*PAYW +: PAYW];
      end
      if (rpush_c[i]) begin
        rq_mem_q[i][rq_rd_q[i] ^ rq_cnt_q[i][0]] <= in_pay_c;
      end
    end
  end

endmodule

// File: tb/tb_bscan_arbiter.sv
// Directed and randomized checks of bscan_arbiter against a queue-based reference model.
module tb_bscan_arbiter;

  localparam int unsigned NCLIENT = 4;
  localparam int unsigned TAGW    = 2;
  localparam int unsigned width   = 32;
  localparam int unsigned PAYW    = 29;

  logic                    CLK;
  logic                    nRST;
  logic [NCLIENT-1:0]      req__ENA;
  logic [NCLIENT*PAYW-1:0] req_v;
  logic [NCLIENT-1:0]      req__RDY;
  logic                    toBscan_enq__ENA;
  logic [width-1:0]        toBscan_enq_v;
  logic                    toBscan_enq__RDY;
  logic                    fromBscan_enq__ENA;
  logic [width-1:0]        fromBscan_enq_v;
  logic                    fromBscan_enq__RDY;
  logic [NCLIENT-1:0]      rsp__ENA;
  logic [NCLIENT*PAYW-1:0] rsp_v;
  logic [NCLIENT-1:0]      rsp__RDY;
  logic [7:0]              drop_cnt;
  logic [15:0]             tx_cnt;

  bscan_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .req__ENA(req__ENA), .req_v(req_v), .req__RDY(req__RDY),
    .toBscan_enq__ENA(toBscan_enq__ENA), .toBscan_enq_v(toBscan_enq_v),
    .toBscan_enq__RDY(toBscan_enq__RDY),
    .fromBscan_enq__ENA(fromBscan_enq__ENA), .fromBscan_enq_v(fromBscan_enq_v),
    .fromBscan_enq__RDY(fromBscan_enq__RDY),
    .rsp__ENA(rsp__ENA), .rsp_v(rsp_v), .rsp__RDY(rsp__RDY),
    .drop_cnt(drop_cnt), .tx_cnt(tx_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PAYW-1:0] m_oq [NCLIENT][$];
  logic [PAYW-1:0] m_rq [NCLIENT][$];
  int m_rr   = 0;
  int m_drop = 0;
  int m_tx   = 0;

  // Values seen mid-cycle, for directed checks
  logic                    obs_to_ena;
  logic [width-1:0]        obs_to_v;
  logic [NCLIENT-1:0]      obs_rsp_ena;
  logic [NCLIENT*PAYW-1:0] obs_rsp_v;
  logic [NCLIENT-1:0]      obs_req_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs with the model at negedge, advance the model, return #1 after posedge
  task automatic cycle();
    logic [NCLIENT-1:0] e_rdy, e_rena;
    logic [width-1:0]   e_tov;
    int w;
    int t;
    @(negedge CLK);
    obs_to_ena  = toBscan_enq__ENA;
    obs_to_v    = toBscan_enq_v;
    obs_rsp_ena = rsp__ENA;
    obs_rsp_v   = rsp_v;
    obs_req_rdy = req__RDY;
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("tx_cnt", 64'(tx_cnt), 64'(m_tx));
    if (nRST) begin
      check("rst_to_ena", 64'(toBscan_enq__ENA), 64'(0));
      check("rst_to_v", 64'(toBscan_enq_v), 64'(0));
      check("rst_rsp_ena", 64'(rsp__ENA), 64'(0));
      check("rst_req_rdy", 64'(req__RDY), 64'(0));
      check("rst_from_rdy", 64'(fromBscan_enq__RDY), 64'(0));
      for (int i = 0; i < NCLIENT; i++) begin
        m_oq[i].delete();
        m_rq[i].delete();
      end
      m_rr = 0; m_drop = 0; m_tx = 0;
    end else begin
      for (int i = 0; i < NCLIENT; i++) begin
        e_rdy[i]  = m_oq[i].size() < 2;
        e_rena[i] = (m_rq[i].size() > 0) && rsp__RDY[i];
      end
      check("req_rdy", 64'(req__RDY), 64'(e_rdy));
      check("from_rdy", 64'(fromBscan_enq__RDY), 64'(1));
      check("to_ena", 64'(toBscan_enq__ENA), 64'(toBscan_enq__RDY));
      check("rsp_ena", 64'(rsp__ENA), 64'(e_rena));
      for (int i = 0; i < NCLIENT; i++)
        if (m_rq[i].size() > 0)
          check($sformatf("rsp_v%0d", i), 64'(rsp_v[i*PAYW +: PAYW]), 64'(m_rq[i][0]));
      w = -1;
      for (int k = 0; k < NCLIENT; k++) begin
        t = (m_rr + k) % NCLIENT;
        if (w < 0 && m_oq[t].size() > 0) w = t;
      end
      if (toBscan_enq__RDY) begin
        e_tov = (w >= 0) ? {1'b1, TAGW'(w), m_oq[w][0]} : '0;
        check("to_v", 64'(toBscan_enq_v), 64'(e_tov));
        if (w >= 0) begin
          void'(m_oq[w].pop_front());
          m_rr = (w + 1) % NCLIENT;
          m_tx = (m_tx + 1) % 65536;
        end
      end
      for (int i = 0; i < NCLIENT; i++)
        if (req__ENA[i] && e_rdy[i]) m_oq[i].push_back(req_v[i*PAYW +: PAYW]);
      for (int i = 0; i < NCLIENT; i++)
        if (e_rena[i]) void'(m_rq[i].pop_front());
      if (fromBscan_enq__ENA && fromBscan_enq_v[width-1]) begin
        t = int'(fromBscan_enq_v[width-2 -: TAGW]);
        if (m_rq[t].size() < 2) m_rq[t].push_back(fromBscan_enq_v[PAYW-1:0]);
        else if (m_drop < 255) m_drop++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req__ENA = '0; req_v = '0; toBscan_enq__RDY = 1'b0;
    fromBscan_enq__ENA = 1'b0; fromBscan_enq_v = '0; rsp__RDY = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    nRST = 1'b1;
    idle_inputs();
    cycle(); cycle();
    nRST = 1'b0;

    // Idle capture straight after reset
    toBscan_enq__RDY = 1'b1;
    cycle();
    check("t1_ena", 64'(obs_to_ena), 64'(1));
    check("t1_idle", 64'(obs_to_v), 64'(0));
    check("t1_tx", 64'(tx_cnt), 64'(0));

    // Three clients, four pulses
    idle_inputs();
    req__ENA = 4'b1101;
    req_v[0*PAYW +: PAYW] = PAYW'(1);
    req_v[2*PAYW +: PAYW] = PAYW'(2);
    req_v[3*PAYW +: PAYW] = PAYW'(3);
    cycle();
    idle_inputs();
    toBscan_enq__RDY = 1'b1;
    cycle(); check("t2_w0", 64'(obs_to_v), 64'h80000001);
    cycle(); check("t2_w1", 64'(obs_to_v), 64'hC0000002);
    cycle(); check("t2_w2", 64'(obs_to_v), 64'hE0000003);
    cycle(); check("t2_w3", 64'(obs_to_v), 64'h00000000);
    check("t2_tx", 64'(tx_cnt), 64'(3));

    // All queues kept full, eight pulses
    idle_inputs();
    req__ENA = '1;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NCLIENT; i++) req_v[i*PAYW +: PAYW] = PAYW'($urandom);
      cycle();
    end
    toBscan_enq__RDY = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NCLIENT; i++) req_v[i*PAYW +: PAYW] = PAYW'($urandom);
      cycle();
      check($sformatf("t3_hdr%0d", n), 64'(obs_to_v[31:29]), 64'({1'b1, TAGW'(n % 4)}));
    end

    // Response overflow on client 1
    idle_inputs();
    rsp__RDY = 4'b1101;
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'hA0000011; cycle();
    fromBscan_enq_v = 32'hA0000012; cycle();
    fromBscan_enq_v = 32'hA0000013; cycle();
    check("t4_drop", 64'(drop_cnt), 64'(1));
    idle_inputs();
    rsp__RDY = '1;
    cycle();
    check("t4_ena0", 64'(obs_rsp_ena[1]), 64'(1));
    check("t4_rsp0", 64'(obs_rsp_v[PAYW +: PAYW]), 64'h11);
    cycle();
    check("t4_ena1", 64'(obs_rsp_ena[1]), 64'(1));
    check("t4_rsp1", 64'(obs_rsp_v[PAYW +: PAYW]), 64'h12);

    // Non-valid inbound word
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h00000055;
    cycle();
    check("t5_ena_a", 64'(obs_rsp_ena), 64'(0));
    idle_inputs();
    rsp__RDY = '1;
    cycle();
    check("t5_ena_b", 64'(obs_rsp_ena), 64'(0));
    check("t5_drop", 64'(drop_cnt), 64'(1));

    // Mid-stream reset with work queued in both directions
    idle_inputs();
    req__ENA = '1;
    rsp__RDY = 4'b1011;
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'hC0000021; cycle();
    fromBscan_enq_v = 32'hC0000022; cycle();
    idle_inputs();
    toBscan_enq__RDY = 1'b1;
    rsp__RDY = '1;
    nRST = 1'b1;
    cycle();
    check("t6_rst_to", 64'(obs_to_ena), 64'(0));
    check("t6_rst_rsp", 64'(obs_rsp_ena), 64'(0));
    nRST = 1'b0;
    cycle();
    check("t6_idle", 64'(obs_to_v), 64'(0));
    check("t6_rdy", 64'(obs_req_rdy), 64'hF);
    check("t6_rsp", 64'(obs_rsp_ena), 64'(0));
    check("t6_drop", 64'(drop_cnt), 64'(0));
    check("t6_tx", 64'(tx_cnt), 64'(0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nRST = ($urandom_range(0, 299) == 0);
      req__ENA = NCLIENT'($urandom);
      for (int i = 0; i < NCLIENT; i++) req_v[i*PAYW +: PAYW] = PAYW'($urandom);
      toBscan_enq__RDY = ($urandom_range(0, 2) != 0);
      fromBscan_enq__ENA = ($urandom_range(0, 3) != 0);
      fromBscan_enq_v = $urandom;
      rsp__RDY = NCLIENT'($urandom) & NCLIENT'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bscan_arbiter.md
# bscan_arbiter

Shares the single 32-bit JTAG user-register channel of the Bscan block among NCLIENT on-chip requesters. Each requester posts payloads through its own small outbound queue. On every capture opportunity the arbiter selects one word round-robin and enqueues it to `toBscan`; if nothing is pending, it sends an idle word. Words arriving on `fromBscan` are steered by tag into per-client response queues, so one host-side JTAG script can talk to several debug agents.

## Interface
Parameters:
- `NCLIENT`, 4: number of requesters; must equal 2^`TAGW`.
- `TAGW`, 2: tag field width.
- `width`, 32: Bscan word width.
- `PAYW`, `width`-1-`TAGW` (29): payload width.

Word format, both directions:
- bit [`width`-1] = valid.
- bits [`width`-2:`PAYW`] = tag (client id).
- bits [`PAYW`-1:0] = payload.
- The idle word is all zeros.

Ports:
- `CLK`  in  1: the single clock; all state is on its rising edge.
- `nRST`  in  1: reset, synchronous and active-high.
- `req__ENA`  in  NCLIENT: per-client enqueue strobe.
- `req_v`  in  NCLIENT*PAYW: per-client payload; client i occupies [i*PAYW +: PAYW].
- `req__RDY`  out  NCLIENT: per-client outbound queue not full.
- `toBscan_enq__ENA`  out  1: word enqueued to Bscan this cycle.
- `toBscan_enq_v`  out  width: word to Bscan.
- `toBscan_enq__RDY`  in  1: Bscan capture window open.
- `fromBscan_enq__ENA`  in  1: word delivered from Bscan.
- `fromBscan_enq_v`  in  width: delivered word.
- `fromBscan_enq__RDY`  out  1: constant 1 outside reset.
- `rsp__ENA`  out  NCLIENT: per-client response valid/strobe.
- `rsp_v`  out  NCLIENT*PAYW: per-client response payload.
- `rsp__RDY`  in  NCLIENT: per-client sink ready.
- `drop_cnt`  out  8: saturating count of valid inbound words dropped because the response queue was full.
- `tx_cnt`  out  16: wrapping count of valid (non-idle) words sent to Bscan.

## Operation
- **Outbound queues:** one 2-entry FIFO per client.
  - `req__RDY[i]` = !full[i], computed from occupancy only (no bypass).
  - A push with `req__ENA[i]` while full is a protocol violation; the queue ignores it.
- **Grant:** in any cycle with `toBscan_enq__RDY`=1, `toBscan_enq__ENA`=1.
  - The winner is the first non-empty queue searching from `rr_ptr` upward, modulo NCLIENT.
  - `toBscan_enq_v` = {1, winner id, head payload}. The winner's head is popped.
  - `rr_ptr` <= winner+1 (mod NCLIENT).
  - If all queues are empty, `toBscan_enq_v` = 0 (idle word), no pop, and `rr_ptr` is unchanged.
- **Simultaneous push and grant on the same client:** pop and push both occur and occupancy is unchanged. If that queue was full, the push is still refused because `req__RDY` was 0.
- **Inbound:** on `fromBscan_enq__ENA`:
  - Valid=0 words are discarded silently.
  - Valid=1 words push their payload into response FIFO[tag] (2-entry).
  - If that FIFO is full and not being popped this cycle, the word is dropped and `drop_cnt` increments, saturating at 255.
  - A push into a full FIFO that is popped in the same cycle is accepted.
- **Response side:** `rsp__ENA[i]` = !empty[i] && `rsp__RDY[i]`, and it pops. `rsp_v[i]` always shows the head.
- **`tx_cnt`:** increments on every non-idle grant and wraps at 16 bits.

## Timing
- **Reset:** `nRST`=1 at a clock edge clears all FIFOs, `rr_ptr`=0, `drop_cnt`=0 and `tx_cnt`=0.
  - While `nRST` is high, all `__ENA` outputs, `req__RDY` and `fromBscan_enq__RDY` are forced to 0.
  - A reset arriving mid-stream discards all queued words in both directions. No partial word is emitted.
- **Latency:**
  - `toBscan_enq__ENA` and `toBscan_enq_v` are combinational from `toBscan_enq__RDY` and the queue heads.
  - A word pushed at edge N is eligible for grant in cycle N+1.
  - An inbound word accepted at edge N appears on `rsp__ENA` in cycle N+1 if the sink is ready.
- **Throughput:** one grant per cycle while RDY is held. A normal capture pulse is 1 cycle, giving one word per JTAG DR scan.
- **Counters** update on the edge of the causing event.

## Test plan
- After reset, hold `toBscan_enq__RDY`=1 for 1 cycle with all queues empty. Expect `toBscan_enq__ENA`=1, `toBscan_enq_v`=0, `tx_cnt`=0 and `rr_ptr`=0.
- Push 0x1 on client 0, 0x2 on client 2 and 0x3 on client 3. Apply 4 capture pulses. Expect words 0x80000001, 0xC0000002, 0xE0000003 and then 0x00000000, with `tx_cnt`=3.
- Keep all 4 queues full and apply 8 pulses. Expect tags in order 0,1,2,3,0,1,2,3, and `req__RDY[i]` re-asserts the cycle after each pop.
- Hold `rsp__RDY[1]`=0 and deliver 3 words with tag 1 (0xA0000011, 0xA0000012, 0xA0000013). Expect the first two queued, the third dropped and `drop_cnt`=1. Then raise `rsp__RDY[1]` and expect payloads 0x11 then 0x12.
- Deliver 0x00000055 (valid=0). Expect no `rsp__ENA` and no `drop_cnt` change.
- Fill queues and hold 2 responses, then pulse `nRST` for 1 cycle. Expect all `__ENA`=0 that cycle, and afterwards empty queues, `drop_cnt`=0, `tx_cnt`=0 and an idle word on the next capture.
